// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: header layout, parser states,
// error codes and the opcode values the ALU core decodes.
package alu_pkg;

    localparam int HDR_OPCODE = 0;
    localparam int HDR_RSVD   = 1;
    localparam int HDR_LEN_LO = 2;
    localparam int HDR_LEN_HI = 3;
    localparam int HDR_BYTES  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RSVD,
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        DISCARD
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] OP_ADD = 8'hA0;
    localparam logic [7:0] OP_SUB = 8'hA1;
    localparam logic [7:0] OP_AND = 8'hA2;
    localparam logic [7:0] OP_OR  = 8'hA3;

    // A packet must carry at least one whole 32-bit operand, a whole number of
    // operands, and fit in the largest frame. len counts the header too, so
    // (len-4)%4==0 reduces to len%4==0.
    function automatic logic len_is_legal(input logic [15:0] len, input int max_len);
        return (len >= 16'd8) && (len[1:0] == 2'b00) && (len <= 16'(max_len));
    endfunction

endpackage

// File: rtl/alu_word_packer.sv
// Packs payload bytes little-endian into 32-bit words and holds each word on
// a valid/ready interface until the ALU takes it.
module alu_word_packer
(
    input  logic        clk,
    input  logic        rst,
    input  logic        idx_clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        first_in,
    input  logic        last_in,
    input  logic        flush,
    input  logic        ready,
    output logic [31:0] word,
    output logic        valid,
    output logic        first,
    output logic        last,
    output logic        overrun
);

    logic [1:0]  idx;
    logic [23:0] shift;
    logic        complete;
    logic        accept;

    assign complete = byte_valid && (idx == 2'd3);
    assign accept   = valid && ready;
    // A fresh word with nowhere to go: the held word must survive untouched.
    assign overrun  = complete && valid && !ready;

    // Byte index and the three lower bytes of the word being assembled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx   <= 2'd0;
            shift <= 24'd0;
        end else begin
            if (idx_clear)
                idx <= 2'd0;
            else if (byte_valid)
                idx <= idx + 2'd1;
            if (byte_valid)
                shift <= {byte_data, shift[23:8]};
        end
    end

    // Output holding register; a same-cycle accept frees the slot for the new word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word  <= 32'd0;
            valid <= 1'b0;
            first <= 1'b0;
            last  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (complete && !overrun) begin
            word  <= {byte_data, shift};
            valid <= 1'b1;
            first <= first_in;
            last  <= last_in;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_packet_parser.sv
// Frames the UART byte stream into ALU command packets, feeds payload words to
// the packer and flags bad-length, overrun and stalled packets.
//
// state   | meaning
// IDLE    | waiting for an opcode byte
// RSVD    | opcode captured, expecting the reserved byte
// LEN_LO  | expecting len[7:0]
// LEN_HI  | expecting len[15:8], length is checked on arrival
// PAYLOAD | payload bytes go to the packer
// DISCARD | swallowing the rest of a rejected packet
module alu_packet_parser
    import alu_pkg::*;
#(
    parameter int MAX_LEN        = 260,
    parameter int TIMEOUT_CYCLES = 50000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  opcode_o,
    output logic [31:0] operand_o,
    output logic        operand_valid_o,
    input  logic        operand_ready_i,
    output logic        first_o,
    output logic        last_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        busy_o
);

    localparam int              TMO_W   = $clog2(TIMEOUT_CYCLES);
    // Hit when the counter would step onto TIMEOUT_CYCLES-1 on this edge.
    localparam logic [TMO_W-1:0] TMO_HIT = TMO_W'(TIMEOUT_CYCLES - 2);

    state_t             state, state_nxt;
    logic [15:0]        remaining, rem_nxt;
    logic [7:0]         len_lo;
    logic [15:0]        len_full;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_hit;
    logic               err_set;
    logic [1:0]         err_code_nxt;
    logic               first_set;
    logic               first_pend;
    logic               pk_byte_valid;
    logic               pk_overrun;
    logic               word_done;
    logic               last_byte;

    assign len_full      = {rx_data_i, len_lo};
    assign tmo_hit       = (state != IDLE) && !rx_valid_i && (tmo_cnt == TMO_HIT);
    assign pk_byte_valid = rx_valid_i && (state == PAYLOAD);
    // remaining starts at a multiple of 4, so a word closes when it is 1 mod 4.
    assign word_done     = pk_byte_valid && (remaining[1:0] == 2'd1);
    assign last_byte     = (remaining == 16'd1);
    assign busy_o        = (state != IDLE);

    // Next-state, remaining-count and error decode.
    always_comb begin
        state_nxt    = state;
        rem_nxt      = remaining;
        err_set      = 1'b0;
        err_code_nxt = err_code_o;
        first_set    = 1'b0;
        if (tmo_hit) begin
            state_nxt    = IDLE;
            err_set      = 1'b1;
            err_code_nxt = ERR_TIMEOUT;
        end else if (rx_valid_i) begin
            case (state)
                IDLE:    state_nxt = RSVD;
                RSVD:    state_nxt = LEN_LO;
                LEN_LO:  state_nxt = LEN_HI;
                LEN_HI: begin
                    if (len_is_legal(len_full, MAX_LEN)) begin
                        state_nxt = PAYLOAD;
                        rem_nxt   = len_full - 16'(HDR_BYTES);
                        first_set = 1'b1;
                    end else begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_BAD_LEN;
                        if (len_full > 16'(HDR_BYTES)) begin
                            state_nxt = DISCARD;
                            rem_nxt   = len_full - 16'(HDR_BYTES);
                        end else begin
                            state_nxt = IDLE;
                            rem_nxt   = 16'd0;
                        end
                    end
                end
                PAYLOAD: begin
                    rem_nxt = (remaining != 16'd0) ? remaining - 16'd1 : 16'd0;
                    if (pk_overrun) begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_OVERRUN;
                        state_nxt    = (remaining <= 16'd1) ? IDLE : DISCARD;
                    end else if (remaining <= 16'd1) begin
                        state_nxt = IDLE;
                    end
                end
                DISCARD: begin
                    rem_nxt = (remaining != 16'd0) ? remaining - 16'd1 : 16'd0;
                    if (remaining <= 16'd1)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and remaining-byte registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= 16'd0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
        end
    end

    // Header captures: opcode on the first byte, low length byte on the third.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode_o <= 8'd0;
            len_lo   <= 8'd0;
        end else if (rx_valid_i) begin
            if (state == IDLE)
                opcode_o <= rx_data_i;
            if (state == LEN_LO)
                len_lo <= rx_data_i;
        end
    end

    // Marks the next completed word as the packet's first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            first_pend <= 1'b0;
        else if (first_set)
            first_pend <= 1'b1;
        else if (word_done)
            first_pend <= 1'b0;
    end

    // Inter-byte idle counter; saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if ((state == IDLE) || rx_valid_i || tmo_hit)
            tmo_cnt <= '0;
        else if (tmo_cnt != {TMO_W{1'b1}})
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // One-cycle error pulse with a sticky cause code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end else begin
            err_o      <= err_set;
            err_code_o <= err_code_nxt;
        end
    end

    alu_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .idx_clear  (state != PAYLOAD),
        .byte_valid (pk_byte_valid),
        .byte_data  (rx_data_i),
        .first_in   (first_pend),
        .last_in    (last_byte),
        .flush      (tmo_hit),
        .ready      (operand_ready_i),
        .word       (operand_o),
        .valid      (operand_valid_o),
        .first      (first_o),
        .last       (last_o),
        .overrun    (pk_overrun)
    );

endmodule

// File: tb/tb_alu_packet_parser.sv
// Directed bench for alu_packet_parser: hand-computed operands, flags and
// error codes for framing, bad length, overrun, timeout and reset cases.
module tb_alu_packet_parser;
    import alu_pkg::*;

    localparam int TMO = 200;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  opcode_o;
    logic [31:0] operand_o;
    logic        operand_valid_o;
    logic        operand_ready_i;
    logic        first_o;
    logic        last_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic        busy_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          err_seen = 0;
    logic [33:0] op_q[$];
    bit          toggle_en = 1'b0;

    alu_packet_parser #(.MAX_LEN(260), .TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data_i       (rx_data_i),
        .rx_valid_i      (rx_valid_i),
        .opcode_o        (opcode_o),
        .operand_o       (operand_o),
        .operand_valid_o (operand_valid_o),
        .operand_ready_i (operand_ready_i),
        .first_o         (first_o),
        .last_o          (last_o),
        .err_o           (err_o),
        .err_code_o      (err_code_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    // Record accepted operands and error pulses away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (operand_valid_o && operand_ready_i)
                op_q.push_back({first_o, last_o, operand_o});
            if (err_o)
                err_seen++;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en)
            operand_ready_i = ~operand_ready_i;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    task automatic send_bytes(input byte_q_t bq);
        foreach (bq[i])
            send_byte(bq[i]);
    endtask

    task automatic wait_ops(input string tag, input int n);
        for (int i = 0; i < 40 && op_q.size() < n; i++)
            tick();
        check_val(tag, 64'(op_q.size()), 64'(n));
    endtask

    initial begin
        int  n;
        bit  seen;
        int  errs0;

        rst             = 1'b0;
        rx_data_i       = 8'h00;
        rx_valid_i      = 1'b0;
        operand_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst opcode", 64'(opcode_o), 64'h0);
        check_val("rst valid/busy/err", 64'({operand_valid_o, busy_o, err_o, err_code_o}), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // 1: two-operand ADD packet, ready high
        op_q.delete();
        send_bytes('{OP_ADD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00});
        check_val("t1 op0 latency", 64'({operand_valid_o, first_o, last_o, operand_o}), {29'd0, 3'b110, 32'h00000001});
        send_bytes('{8'h02, 8'h00, 8'h00, 8'h00});
        check_val("t1 op1 latency", 64'({operand_valid_o, first_o, last_o, operand_o}), {29'd0, 3'b101, 32'h00000002});
        wait_ops("t1 op count", 2);
        if (op_q.size() == 2) begin
            check_val("t1 op0", 64'(op_q[0]), 64'({2'b10, 32'h00000001}));
            check_val("t1 op1", 64'(op_q[1]), 64'({2'b01, 32'h00000002}));
        end
        check_val("t1 opcode", 64'(opcode_o), 64'hA0);
        check_val("t1 busy", 64'(busy_o), 64'h0);
        check_val("t1 errs", 64'(err_seen), 64'd0);

        // 2: len=9 is rejected, 5 bytes discarded, then a good packet
        op_q.delete();
        send_bytes('{OP_SUB, 8'h00, 8'h09, 8'h00});
        check_val("t2 err pulse", 64'({err_o, err_code_o}), 64'({1'b1, ERR_BAD_LEN}));
        check_val("t2 discarding", 64'(busy_o), 64'h1);
        send_bytes('{8'h11, 8'h22, 8'h33, 8'h44});
        check_val("t2 still discarding", 64'(busy_o), 64'h1);
        send_byte(8'h55);
        check_val("t2 discard done", 64'(busy_o), 64'h0);
        send_bytes('{OP_ADD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
        wait_ops("t2 op count", 1);
        if (op_q.size() == 1)
            check_val("t2 op0", 64'(op_q[0]), 64'({2'b11, 32'h12345678}));
        check_val("t2 errs", 64'(err_seen), 64'd1);

        // 3: len=16 with ready low, second word overruns
        op_q.delete();
        operand_ready_i = 1'b0;
        send_bytes('{OP_AND, 8'h00, 8'h10, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
        check_val("t3 held", 64'({operand_valid_o, operand_o}), 64'({1'b1, 32'h44332211}));
        send_bytes('{8'h55, 8'h66, 8'h77, 8'h88});
        check_val("t3 overrun pulse", 64'({err_o, err_code_o}), 64'({1'b1, ERR_OVERRUN}));
        check_val("t3 word kept", 64'({operand_valid_o, first_o, operand_o}), 64'({2'b11, 32'h44332211}));
        send_bytes('{8'h99, 8'hAA, 8'hBB});
        check_val("t3 busy at 15", 64'(busy_o), 64'h1);
        send_byte(8'hCC);
        check_val("t3 busy at 16", 64'(busy_o), 64'h0);
        operand_ready_i = 1'b1;
        wait_ops("t3 op count", 1);
        if (op_q.size() == 1)
            check_val("t3 op0", 64'(op_q[0]), 64'({2'b10, 32'h44332211}));
        check_val("t3 errs", 64'(err_seen), 64'd2);

        // 4: stall after 6 bytes of a 12-byte packet
        send_bytes('{OP_ADD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02});
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 2 * TMO && !seen; i++) begin
            tick();
            n++;
            if (err_o)
                seen = 1'b1;
        end
        check_val("t4 timeout seen", 64'(seen), 64'h1);
        check_val("t4 timeout latency", 64'(n), 64'(TMO - 1));
        check_val("t4 code/busy", 64'({err_code_o, busy_o}), 64'({ERR_TIMEOUT, 1'b0}));
        tick();
        check_val("t4 pulse width", 64'(err_o), 64'h0);

        // 5: async reset mid-payload with an operand held
        op_q.delete();
        operand_ready_i = 1'b0;
        send_bytes('{OP_OR, 8'h00, 8'h0C, 8'h00, 8'h0D, 8'h0C, 8'h0B, 8'h0A});
        check_val("t5 pre-reset", 64'({busy_o, operand_valid_o, opcode_o}), 64'({2'b11, 8'hA3}));
        #2;
        rst = 1'b0;
        #1;
        check_val("t5 rst opcode/operand", 64'({opcode_o, operand_o}), 64'h0);
        check_val("t5 rst flags", 64'({operand_valid_o, first_o, last_o, err_o, err_code_o, busy_o}), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        operand_ready_i = 1'b1;
        tick();
        op_q.delete();
        send_bytes('{OP_ADD, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        wait_ops("t5 op count", 1);
        if (op_q.size() == 1)
            check_val("t5 op0", 64'(op_q[0]), 64'({2'b11, 32'hDEADBEEF}));

        // 6: two back-to-back packets, ready toggling every cycle
        op_q.delete();
        errs0     = err_seen;
        toggle_en = 1'b1;
        send_bytes('{OP_ADD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                     8'h05, 8'h06, 8'h07, 8'h08,
                     OP_SUB, 8'h00, 8'h0C, 8'h00, 8'h09, 8'h0A, 8'h0B, 8'h0C,
                     8'h0D, 8'h0E, 8'h0F, 8'h10});
        wait_ops("t6 op count", 4);
        toggle_en = 1'b0;
        if (op_q.size() == 4) begin
            check_val("t6 op0", 64'(op_q[0]), 64'({2'b10, 32'h04030201}));
            check_val("t6 op1", 64'(op_q[1]), 64'({2'b01, 32'h08070605}));
            check_val("t6 op2", 64'(op_q[2]), 64'({2'b10, 32'h0C0B0A09}));
            check_val("t6 op3", 64'(op_q[3]), 64'({2'b01, 32'h100F0E0D}));
        end
        check_val("t6 opcode", 64'(opcode_o), 64'hA1);
        check_val("t6 errs", 64'(err_seen - errs0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
